// File: rtl/wam_pkg.sv
// wam_pkg: shared types and constants for the Whac-A-Mole round controller.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    GAP  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int unsigned LEVEL_W   = 3;
  localparam int unsigned LIFE_W    = 4;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  // Galois right-shift step for x^8+x^6+x^5+x^4+1 (tap mask 8'hB8).
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// wam_lfsr: free-running 8-bit Galois LFSR; clr reloads the seed.
// Only the low three bits leave the block, since they are all the mole
// selector needs.
module wam_lfsr
  import wam_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  output logic [2:0] rnd
);

  logic [7:0] lfsr;

  assign rnd = lfsr[2:0];

  // Advance the sequence every cycle, regardless of game state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

endmodule

// File: rtl/wam_ctl.sv
// wam_ctl: Whac-A-Mole round controller and difficulty scheduler.
// Optional feature macro: WAM_PENALTY_EN (wrong presses in UP cost 2 ticks).
module wam_ctl
  import wam_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned GAME_TICKS = 60,
  parameter int unsigned LIFE0      = 4,
  parameter int unsigned LIFE_MIN   = 1,
  parameter int unsigned LEVEL_MAX  = 7
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [7:0]         btn,
  input  logic               lvl_up,
  output logic [7:0]         mole,
  output logic [7:0]         hit,
  output logic               scr_clr,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         time_left,
  output logic [1:0]         state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRE_TOP     = PW'(TICK_DIV - 1);
  localparam logic [LIFE_W-1:0]  LIFE0_V     = LIFE_W'(LIFE0);
  localparam logic [LIFE_W-1:0]  LIFE_MIN_V  = LIFE_W'(LIFE_MIN);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX_V = LEVEL_W'(LEVEL_MAX);
  localparam logic [7:0]         GAME_V      = 8'(GAME_TICKS);

  state_t             st;
  logic [7:0]         btn_q;
  logic [7:0]         press;
  logic [2:0]         lv_s;
  logic [PW-1:0]      pre;
  logic [PW-1:0]      gap_cnt;
  logic [LIFE_W-1:0]  life;
  logic [2:0]         cur_idx;

  logic [2:0]         rnd;
  logic [2:0]         nidx;
  logic [LIFE_W-1:0]  lvl_ext;
  logic [LIFE_W-1:0]  life_load;
  logic [7:0]         dec;
  logic [7:0]         tl_next;
  logic               active;
  logic               tick;
  logic               gap_done;
  logic               good;
  logic               pen;
  logic               lvl_rise;

  wam_lfsr u_lfsr (
    .clk (clk),
    .clr (clr),
    .rnd (rnd)
  );

  assign state    = st;
  assign active   = (st == UP) || (st == GAP);
  assign tick     = active && (pre == PRE_TOP);
  assign gap_done = (gap_cnt == PRE_TOP);
  assign good     = (st == UP) && (|(press & mole));
  assign lvl_rise = lv_s[1] & ~lv_s[2];

`ifdef WAM_PENALTY_EN
  assign pen = (st == UP) && (|(press & ~mole));
`else
  assign pen = 1'b0;
`endif

  // Next mole index (never repeats the last one), lifetime for the current
  // level, and the round-timer decrement (tick plus optional penalty).
  always_comb begin
    nidx = rnd;
    if (rnd == cur_idx) nidx = rnd + 3'd1;
    lvl_ext   = {1'b0, level};
    life_load = (LIFE0_V > lvl_ext) ? (LIFE0_V - lvl_ext) : '0;
    if (life_load < LIFE_MIN_V) life_load = LIFE_MIN_V;
    dec     = {6'd0, pen, tick};
    tl_next = (time_left > dec) ? (time_left - dec) : '0;
  end

  // Round FSM with edge detection, level synchroniser, timers and outputs.
  // A hit is issued even on the cycle the round ends; round end then
  // overrides the UP/GAP transition so no new mole can rise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st        <= IDLE;
      btn_q     <= '0;
      press     <= '0;
      lv_s      <= '0;
      pre       <= '0;
      gap_cnt   <= '0;
      life      <= '0;
      cur_idx   <= '0;
      mole      <= '0;
      hit       <= '0;
      scr_clr   <= 1'b0;
      level     <= '0;
      time_left <= '0;
    end else begin
      btn_q   <= btn;
      press   <= btn & ~btn_q;
      lv_s    <= {lv_s[1:0], lvl_up};
      hit     <= '0;
      scr_clr <= 1'b0;
      unique case (st)
        IDLE, OVER: begin
          mole    <= '0;
          pre     <= '0;
          gap_cnt <= '0;
          if (start) begin
            scr_clr   <= 1'b1;
            level     <= '0;
            time_left <= GAME_V;
            st        <= GAP;
          end
        end
        UP, GAP: begin
          pre       <= tick ? '0 : pre + 1'b1;
          time_left <= tl_next;
          if (lvl_rise && (level != LEVEL_MAX_V)) level <= level + 1'b1;
          if (st == UP) begin
            hit <= press & mole;
            if (tick) life <= (life != '0) ? life - 1'b1 : '0;
          end
          if (tl_next == '0) begin
            mole <= '0;
            st   <= OVER;
          end else if (st == UP) begin
            if (good || (tick && (life <= LIFE_W'(1)))) begin
              mole    <= '0;
              gap_cnt <= '0;
              st      <= GAP;
            end
          end else if (gap_done) begin
            cur_idx <= nidx;
            mole    <= 8'd1 << nidx;
            life    <= life_load;
            st      <= UP;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wam_ctl.sv
// tb_wam_ctl: randomized scoreboard bench for wam_ctl. A game-level model
// (timeline of tick edges, mole rise/fall edges, level events) pushes the
// expected outputs for every clock edge; a monitor pops and compares.
module tb_wam_ctl;

  localparam int TD   = 4;
  localparam int GT   = 20;
  localparam int L0   = 4;
  localparam int LMIN = 1;
  localparam int LMAX = 3;
`ifdef WAM_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] btn;
  logic       lvl_up;
  logic [7:0] mole;
  logic [7:0] hit;
  logic       scr_clr;
  logic [2:0] level;
  logic [7:0] time_left;
  logic [1:0] state;

  wam_ctl #(
    .TICK_DIV   (TD),
    .GAME_TICKS (GT),
    .LIFE0      (L0),
    .LIFE_MIN   (LMIN),
    .LEVEL_MAX  (LMAX)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .btn       (btn),
    .lvl_up    (lvl_up),
    .mole      (mole),
    .hit       (hit),
    .scr_clr   (scr_clr),
    .level     (level),
    .time_left (time_left),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] mole;
    logic [7:0] hit;
    logic [7:0] tl;
    logic [2:0] level;
    logic [1:0] st;
    logic       scr;
  } exp_t;
  exp_t exp_q[$];

  // Model state
  logic [7:0] lfsr_m = 8'hA5;
  bit   started  = 0;
  bit   round_on = 0;
  bit   m_up     = 0;
  bit   m_scr    = 0;
  int   S = 0, tl_m = 0, lvl_m = 0, m_idx = 0, prev_idx = 0, m_fall = 0, m_rise = 0;
  logic [7:0] pend_bits = '0;
  int   pend_edge = -1;
  int   lvl_q[$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n[7] = s[0];
    n[6] = s[7];
    n[5] = s[6] ^ s[0];
    n[4] = s[5] ^ s[0];
    n[3] = s[4] ^ s[0];
    n[2] = s[3];
    n[1] = s[2];
    n[0] = s[1];
    return n;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_step();
    exp_t       e;
    logic [7:0] lf;
    bit         hitb, wrong, tk;
    int         dec, nl, life, ni, first_tick;
    cyc   = cyc + 1;
    lf    = lfsr_m;
    e.hit = '0;
    m_scr = 0;
    if (clr) begin
      lfsr_m = 8'hA5;
      started = 0; round_on = 0; m_up = 0;
      tl_m = 0; lvl_m = 0; prev_idx = 0; pend_edge = -1;
      lvl_q.delete();
    end else begin
      lfsr_m = lfsr_step(lf);
      nl = lvl_m;
      if (!round_on) begin
        if (start) begin
          started = 1; round_on = 1; S = cyc; tl_m = GT; nl = 0;
          m_up = 0; m_rise = cyc + TD; m_scr = 1;
        end
      end else begin
        hitb  = m_up && (pend_edge == cyc) && pend_bits[m_idx];
        wrong = m_up && (pend_edge == cyc) && ((pend_bits & ~(8'd1 << m_idx)) != 0);
        tk    = ((cyc - S) % TD) == 0;
        dec   = int'(tk) + ((PEN && wrong) ? 2 : 0);
        tl_m  = (tl_m > dec) ? tl_m - dec : 0;
        if (hitb) e.hit = 8'd1 << m_idx;
        if (lvl_q.size() > 0 && lvl_q[0] == cyc && lvl_m < LMAX) nl = lvl_m + 1;
        if (tl_m == 0) begin
          round_on = 0; m_up = 0;
        end else if (m_up) begin
          if (hitb || cyc == m_fall) begin
            m_up = 0; m_rise = cyc + TD;
          end
        end else if (cyc == m_rise) begin
          ni = int'(lf[2:0]);
          if (ni == prev_idx) ni = (ni + 1) % 8;
          prev_idx = ni; m_idx = ni;
          life = L0 - lvl_m;
          if (life < LMIN) life = LMIN;
          first_tick = S + TD * ((cyc - S) / TD + 1);
          m_fall = first_tick + TD * (life - 1);
          m_up = 1;
        end
      end
      lvl_m = nl;
    end
    while (lvl_q.size() > 0 && lvl_q[0] <= cyc) void'(lvl_q.pop_front());
    e.mole  = m_up ? (8'd1 << m_idx) : 8'd0;
    e.tl    = 8'(tl_m);
    e.level = 3'(lvl_m);
    e.st    = !started ? 2'd0 : (round_on ? (m_up ? 2'd1 : 2'd2) : 2'd3);
    e.scr   = m_scr;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  logic [7:0] prev_mole = '0;
  logic [7:0] last_up   = '0;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mole", mole, e.mole);
      chk("hit", hit, e.hit);
      chk("time_left", time_left, e.tl);
      chk("level", {5'd0, level}, {5'd0, e.level});
      chk("state", {6'd0, state}, {6'd0, e.st});
      chk("scr_clr", {7'd0, scr_clr}, {7'd0, e.scr});
    end
    if (clr) last_up = '0;
    else if (mole != 0 && prev_mole == 0) begin
      if (last_up != 0) begin
        checks++;
        if (mole == last_up) begin
          failures++;
          $display("FAIL mole_repeat cyc=%0d got=%0h previous=%0h", cyc, mole, last_up);
        end
      end
      last_up = mole;
    end
    prev_mole = mole;
  end

  task automatic press(input logic [7:0] bits);
    btn       = bits;
    pend_bits = bits;
    pend_edge = cyc + 2;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask

  task automatic pulse_lvl();
    lvl_up = 1'b1;
    lvl_q.push_back(cyc + 3);
    @(negedge clk);
    lvl_up = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic step_random();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5 && mole != 0) press(mole);
    else if (r == 5) press(8'($urandom_range(1, 255)));
    else @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] want, input int budget, input string name);
    int t;
    t = 0;
    while (state != want && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (state != want) begin
      failures++;
      $display("FAIL %s timeout got_state=%0d expected=%0d", name, state, want);
    end
  endtask

  initial begin
    int  t0, t, k, fe;
    bit  done;
    clr = 1'b1; start = 1'b0; btn = '0; lvl_up = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Round A: never press, every mole expires after the level-0 lifetime.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(2'd3, 200, "round_a_end");

    // Presses while OVER must give no hit.
    repeat (3) press(8'($urandom_range(1, 255)));

    // Round B with start held: level-ups, random presses, and an immediate
    // restart into round C when B ends.
    start = 1'b1;
    @(negedge clk);
    repeat (5) pulse_lvl();
    t0 = cyc;
    while (cyc < t0 + 100) step_random();
    start = 1'b0;

    // Round C: press timed to land on the same edge as lifetime expiry.
    done = 0; t = 0;
    while (!done && t < 300) begin
      if (m_up && cyc == m_fall - 2 && tl_m >= 2 && state == 2'd1) begin
        k  = m_idx;
        fe = m_fall;
        press(8'd1 << k);
        chk("collision_edge", 8'(cyc - fe), 8'd0);
        chk("collision_hit", hit, 8'd1 << k);
        done = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL collision timeout got=none expected=hit");
    end

`ifdef WAM_PENALTY_EN
    // Wrong press close to round end drives time_left to zero.
    t = 0;
    while (state != 2'd3 && t < 300) begin
      if (m_up && tl_m <= 2 && state == 2'd1) begin
        press(8'd1 << ((m_idx + $urandom_range(1, 7)) % 8));
        break;
      end
      @(negedge clk);
      t++;
    end
`endif
    wait_state(2'd3, 300, "round_c_end");
    repeat (2) press(8'($urandom_range(1, 255)));

    // Round D: random play then asynchronous clear mid-round.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 30) step_random();
    clr = 1'b1;
    #1;
    chk("clr_async_state", {6'd0, state}, 8'd0);
    chk("clr_async_mole", mole, 8'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
